gshare_btb_predictor: RTL and testbench
=======================================

// Module: gshare_btb_predictor
// PURPOSE
//  Parametrised gshare direction predictor with tagged direct-mapped BTB. Sits beside FE: predicts next PC combinationally
//  from FE PC; trained by branch resolution from AGEX, which also triggers flush/redirect. Adds over prior predictor:
//  sized tables, speculative GHR with checkpoint restore, unconditional-branch type bit, PHT init FSM.
// PARAMETERS
//  PC_BITS      32  PC width; instructions 4-byte aligned, PC[1:0] ignored
//  GHR_BITS     8   global history length; PHT depth = 2**GHR_BITS entries x 2b
//  BTB_IDX_BITS 4   BTB depth = 2**BTB_IDX_BITS; tag = PC[PC_BITS-1:BTB_IDX_BITS+2]
// PORTS
//  clk            in   1             clock, all state on rising edge
//  reset          in   1             asynchronous, active-low
//  fe_valid       in   1             FE presents fe_pc this cycle
//  fe_pc          in   PC_BITS       fetch PC to predict
//  pred_taken     out  1             predicted taken (BTB hit && (uncond || PHT>=2))
//  pred_pc        out  PC_BITS       next fetch PC (target if pred_taken, else fe_pc+4)
//  pred_ghr       out  GHR_BITS      GHR used for this prediction; FE carries it to AGEX
//  res_valid      in   1             AGEX resolves a branch/jump this cycle
//  res_pc         in   PC_BITS       PC of resolved branch
//  res_taken      in   1             actual direction
//  res_target     in   PC_BITS       actual taken target
//  res_uncond     in   1             unconditional jump
//  res_pred_taken in   1             prediction carried down pipe
//  res_pred_pc    in   PC_BITS       predicted next PC carried down pipe
//  res_ghr        in   GHR_BITS      pred_ghr carried down pipe
//  flush          out  1             mispredict; kill FE/DE
//  redirect_pc    out  PC_BITS       correct next PC when flush
//  bp_ready       out  1             init complete
// BEHAVIOUR
//  Reset: state<=INIT, init_cnt<=0, GHR<=0, all BTB valid<=0; outputs pred_taken=0, flush=0, bp_ready=0.
//  FSM INIT: write PHT[init_cnt]=2'b01 (weak NT), init_cnt++; at init_cnt==2**GHR_BITS-1 -> RUN next cycle. RUN: stays
//   until reset. INIT lasts exactly 2**GHR_BITS cycles. Reset assertion mid-operation (incl. mid-INIT) restarts INIT.
//  During INIT: pred_taken=0, pred_pc=fe_pc+4, res_* ignored, flush=0, GHR held.
//  Lookup (combinational, zero latency): pht_idx=fe_pc[GHR_BITS+1:2]^GHR; btb_idx=fe_pc[BTB_IDX_BITS+1:2];
//   hit = valid && tag match. pred_ghr=GHR. fe_pc+4 wraps modulo 2**PC_BITS.
//  Flush (combinational, RUN only): flush = res_valid && (res_taken!=res_pred_taken ||
//   (res_taken && res_target!=res_pred_pc)). redirect_pc = res_taken ? res_target : res_pc+4.
//  GHR update, priority order: (1) flush: GHR<={res_ghr[GHR_BITS-2:0],res_taken}; (2) fe_valid && BTB hit:
//   GHR<={GHR[GHR_BITS-2:0],pred_taken} (speculative); (3) hold. Non-hit fetches do not shift GHR.
//  PHT train on res_valid && !res_uncond: idx=res_pc[GHR_BITS+1:2]^res_ghr; 2b saturating: taken +1 to max 3,
//   not-taken -1 to min 0. Uncond jumps do not touch PHT.
//  BTB write on res_valid && res_taken: entry[res_pc idx] <= {valid=1, tag, res_uncond, res_target}; overwrites alias.
//   Not-taken resolution leaves BTB unchanged.
//  Same-cycle lookup and train of same PHT/BTB entry: lookup sees pre-edge value; new value visible next cycle.
// CONFIGURATION
//  BP_STATS_EN defined: adds outputs stat_branches[31:0] (res_valid count in RUN) and stat_mispred[31:0] (flush count);
//   reset to 0, wrap at 2**32. Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset, GHR_BITS=8 -> bp_ready=0 for 256 cycles, 1 on cycle 256; pred_pc=fe_pc+4 throughout INIT.
//  fe_pc=0x100 cold -> pred_pc=0x104; res taken pc=0x100 target=0x40, res_pred_pc=0x104 -> flush=1, redirect=0x40.
//  Resolve pc=0x100 taken, ghr=0, twice -> PHT 01->10->11; lookup with GHR=0 -> pred_taken=1, pred_pc=0x40.
//  Flush with res_ghr=0x5A, res_taken=1 same cycle as BTB-hit fetch -> GHR=0xB5 next cycle (flush wins).
//  Train 0x100 then 0x140 (same idx, diff tag) taken -> lookup 0x100 misses, pred_pc=0x104.
//  BP_STATS_EN: 10 resolves, 3 mispredicts -> stat_branches=10, stat_mispred=3; async reset mid-run clears both.

Source files
------------

// File: rtl/gshare_btb_predictor.sv
// -----------------------------------------------------------------------------
// gshare_btb_predictor
//
// Purpose:
//   Gshare direction predictor (2-bit saturating PHT indexed by PC ^ GHR) with a
//   tagged direct-mapped BTB. Prediction is combinational from the fetch PC.
//   Training, flush detection and redirect come from the branch resolution
//   stage. The GHR is updated speculatively on BTB-hit fetches and restored
//   from the carried-down checkpoint (res_ghr) on a mispredict. After reset a
//   small FSM walks the PHT writing weakly-not-taken into every entry.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   fe_valid, fe_pc     fetch request
//   pred_taken/pc/ghr   prediction for fe_pc and the GHR it used
//   res_*               branch resolution (actual outcome + carried prediction)
//   flush, redirect_pc  mispredict indication and correct next PC
//   bp_ready            PHT initialisation finished
//   dbg_state           current FSM state (0 = INIT, 1 = RUN)
//
// Handshake: fe_valid qualifies fe_pc only for the speculative GHR shift; the
//   prediction outputs always reflect fe_pc. res_valid qualifies all res_*
//   inputs for one cycle; there is no backpressure on either side.
//
// Configuration macro:
//   BP_STATS_EN  adds stat_branches / stat_mispred counters and ports.
//
// Requires GHR_BITS >= 2.
// -----------------------------------------------------------------------------
module gshare_btb_predictor #(
  parameter int PC_BITS      = 32,
  parameter int GHR_BITS     = 8,
  parameter int BTB_IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fe_valid,
  input  logic [PC_BITS-1:0]  fe_pc,
  output logic                pred_taken,
  output logic [PC_BITS-1:0]  pred_pc,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                res_valid,
  input  logic [PC_BITS-1:0]  res_pc,
  input  logic                res_taken,
  input  logic [PC_BITS-1:0]  res_target,
  input  logic                res_uncond,
  input  logic                res_pred_taken,
  input  logic [PC_BITS-1:0]  res_pred_pc,
  input  logic [GHR_BITS-1:0] res_ghr,
  output logic                flush,
  output logic [PC_BITS-1:0]  redirect_pc,
  output logic                bp_ready,
  output logic                dbg_state
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispred
`endif
);

  localparam int PHT_DEPTH = 1 << GHR_BITS;
  localparam int BTB_DEPTH = 1 << BTB_IDX_BITS;
  localparam int TAG_W     = PC_BITS - BTB_IDX_BITS - 2;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]          state_q, state_d;
  logic [GHR_BITS-1:0] init_cnt_q, init_cnt_d;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [BTB_DEPTH-1:0] btb_valid_q, btb_valid_d;

  // Table payloads carry no reset: PHT is filled by the INIT walk, BTB payload
  // is qualified by btb_valid_q.
  logic [1:0]          pht_q        [PHT_DEPTH];
  logic [TAG_W-1:0]    btb_tag_q    [BTB_DEPTH];
  logic [PC_BITS-1:0]  btb_target_q [BTB_DEPTH];
  logic [BTB_DEPTH-1:0] btb_uncond_q;

  logic run;
  assign run = (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [GHR_BITS-1:0]     fe_pht_idx;
  logic [BTB_IDX_BITS-1:0] fe_btb_idx;
  logic [TAG_W-1:0]        fe_tag;
  logic                    fe_hit;

  assign fe_pht_idx = fe_pc[GHR_BITS+1:2] ^ ghr_q;
  assign fe_btb_idx = fe_pc[BTB_IDX_BITS+1:2];
  assign fe_tag     = fe_pc[PC_BITS-1:BTB_IDX_BITS+2];
  assign fe_hit     = btb_valid_q[fe_btb_idx] && (btb_tag_q[fe_btb_idx] == fe_tag);

  assign pred_taken = run && fe_hit && (btb_uncond_q[fe_btb_idx] || pht_q[fe_pht_idx][1]);
  assign pred_pc    = pred_taken ? btb_target_q[fe_btb_idx] : (fe_pc + PC_BITS'(4));
  assign pred_ghr   = ghr_q;

  // ---------------------------------------------------------------------------
  // Resolution
  // ---------------------------------------------------------------------------
  logic                    res_act;
  logic [GHR_BITS-1:0]     res_pht_idx;
  logic [BTB_IDX_BITS-1:0] res_btb_idx;
  logic [1:0]              res_ctr;

  assign res_act     = run && res_valid;
  assign res_pht_idx = res_pc[GHR_BITS+1:2] ^ res_ghr;
  assign res_btb_idx = res_pc[BTB_IDX_BITS+1:2];
  assign res_ctr     = pht_q[res_pht_idx];

  assign flush       = res_act && ((res_taken != res_pred_taken) ||
                                   (res_taken && (res_target != res_pred_pc)));
  assign redirect_pc = res_taken ? res_target : (res_pc + PC_BITS'(4));

  assign bp_ready  = run;
  assign dbg_state = state_q;

  // Checkpoint MSB falls off the shift on restore.
  logic unused_ghr_msb;
  assign unused_ghr_msb = res_ghr[GHR_BITS-1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic                pht_we;
  logic [GHR_BITS-1:0] pht_widx;
  logic [1:0]          pht_wdata;
  logic                btb_we;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + GHR_BITS'(1);
      if (init_cnt_q == {GHR_BITS{1'b1}}) state_d = ST_RUN;
    end
  end

  // Restore on mispredict beats the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (run) begin
      if (flush)                  ghr_d = {res_ghr[GHR_BITS-2:0], res_taken};
      else if (fe_valid && fe_hit) ghr_d = {ghr_q[GHR_BITS-2:0], pred_taken};
    end
  end

  // Single PHT write port shared by the INIT walk and training.
  always_comb begin
    pht_we    = 1'b0;
    pht_widx  = res_pht_idx;
    pht_wdata = 2'b01;
    if (!run) begin
      pht_we   = 1'b1;
      pht_widx = init_cnt_q;
    end else if (res_valid && !res_uncond) begin
      pht_we = 1'b1;
      if (res_taken) pht_wdata = (res_ctr == 2'b11) ? 2'b11 : res_ctr + 2'b01;
      else           pht_wdata = (res_ctr == 2'b00) ? 2'b00 : res_ctr - 2'b01;
    end
  end

  assign btb_we = res_act && res_taken;

  always_comb begin
    btb_valid_d = btb_valid_q;
    if (btb_we) btb_valid_d[res_btb_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      ghr_q       <= '0;
      btb_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ghr_q       <= ghr_d;
      btb_valid_q <= btb_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_widx] <= pht_wdata;
    if (btb_we) begin
      btb_tag_q[res_btb_idx]    <= res_pc[PC_BITS-1:BTB_IDX_BITS+2];
      btb_target_q[res_btb_idx] <= res_target;
      btb_uncond_q[res_btb_idx] <= res_uncond;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_branches_d = stat_branches_q + {31'b0, res_act};
    stat_mispred_d  = stat_mispred_q + {31'b0, flush};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// -----------------------------------------------------------------------------
// tb_gshare_btb_predictor
//
// Directed bench for gshare_btb_predictor (default parameters). The driver
// sets inputs just after the rising edge and queues the values the outputs
// must show in that cycle; a monitor on the falling edge pops and compares.
// Define BP_STATS_EN to also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_gshare_btb_predictor;

  localparam int PC_BITS      = 32;
  localparam int GHR_BITS     = 8;
  localparam int BTB_IDX_BITS = 4;

  localparam int SEL_TAKEN  = 0;
  localparam int SEL_PC     = 1;
  localparam int SEL_GHR    = 2;
  localparam int SEL_FLUSH  = 3;
  localparam int SEL_REDIR  = 4;
  localparam int SEL_READY  = 5;
  localparam int SEL_STATE  = 6;
  localparam int SEL_ST_BR  = 7;
  localparam int SEL_ST_MP  = 8;

  logic                clk;
  logic                reset;
  logic                fe_valid;
  logic [PC_BITS-1:0]  fe_pc;
  logic                pred_taken;
  logic [PC_BITS-1:0]  pred_pc;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                res_valid;
  logic [PC_BITS-1:0]  res_pc;
  logic                res_taken;
  logic [PC_BITS-1:0]  res_target;
  logic                res_uncond;
  logic                res_pred_taken;
  logic [PC_BITS-1:0]  res_pred_pc;
  logic [GHR_BITS-1:0] res_ghr;
  logic                flush;
  logic [PC_BITS-1:0]  redirect_pc;
  logic                bp_ready;
  logic                dbg_state;
`ifdef BP_STATS_EN
  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispred;
`endif

  gshare_btb_predictor #(
    .PC_BITS(PC_BITS), .GHR_BITS(GHR_BITS), .BTB_IDX_BITS(BTB_IDX_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .fe_valid(fe_valid), .fe_pc(fe_pc),
    .pred_taken(pred_taken), .pred_pc(pred_pc), .pred_ghr(pred_ghr),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_uncond(res_uncond),
    .res_pred_taken(res_pred_taken), .res_pred_pc(res_pred_pc), .res_ghr(res_ghr),
    .flush(flush), .redirect_pc(redirect_pc), .bp_ready(bp_ready),
    .dbg_state(dbg_state)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] dut_value(input int sel);
    logic [31:0] v;
    v = 32'hDEAD_BEEF;
    case (sel)
      SEL_TAKEN: v = {31'b0, pred_taken};
      SEL_PC:    v = pred_pc;
      SEL_GHR:   v = {24'b0, pred_ghr};
      SEL_FLUSH: v = {31'b0, flush};
      SEL_REDIR: v = redirect_pc;
      SEL_READY: v = {31'b0, bp_ready};
      SEL_STATE: v = {31'b0, dbg_state};
`ifdef BP_STATS_EN
      SEL_ST_BR: v = stat_branches;
      SEL_ST_MP: v = stat_mispred;
`endif
      default:   v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  exp_t        mon_e;
  logic [31:0] mon_act;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = dut_value(mon_e.sel);
      checks++;
      if (mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", mon_e.name, mon_act, mon_e.val, $time);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_chk(input int sel, input logic [31:0] v, input string name);
    exp_t e;
    e.sel  = sel;
    e.val  = v;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drive_fe(input logic v, input logic [31:0] pc);
    fe_valid = v;
    fe_pc    = pc;
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic unc, input logic ptk, input logic [31:0] ppc,
                           input logic [7:0] g);
    res_valid      = 1'b1;
    res_pc         = pc;
    res_taken      = tk;
    res_target     = tgt;
    res_uncond     = unc;
    res_pred_taken = ptk;
    res_pred_pc    = ppc;
    res_ghr        = g;
  endtask

  task automatic res_idle();
    res_valid = 1'b0;
  endtask

  task automatic exp_pred(input logic tk, input logic [31:0] pc, input string name);
    exp_chk(SEL_TAKEN, {31'b0, tk}, {name, "_taken"});
    exp_chk(SEL_PC, pc, {name, "_pc"});
  endtask

  // Walks the INIT period after reset release; checks bp_ready edge timing.
  task automatic init_walk(input bit full, input logic [31:0] last_pc);
    logic [31:0] pc;
    for (int k = 0; k <= 256; k++) begin
      if (k > 0) step();
      if (k == 256) begin
        res_idle();
        pc = last_pc;
      end else begin
        pc = (k == 5) ? 32'hFFFF_FFFC : 32'h0000_1000 + 32'(k) * 4;
        drive_res(32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 32'h104, 8'h00);
      end
      drive_fe(1'b1, pc);
      if (full || k == 0 || k >= 255) begin
        exp_chk(SEL_READY, {31'b0, (k == 256)}, "init_ready");
        exp_pred(1'b0, pc + 32'd4, "init");
        if (k < 256) exp_chk(SEL_FLUSH, 32'd0, "init_flush");
        exp_chk(SEL_GHR, 32'd0, "init_ghr");
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    drive_fe(1'b0, 32'h0);
    res_idle();
    drive_res(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 8'h0);
    res_idle();
    step();

    // In reset: everything quiet even with a mispredicting resolution present.
    drive_fe(1'b1, 32'h100);
    drive_res(32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 32'h104, 8'h00);
    exp_chk(SEL_READY, 32'd0, "rst_ready");
    exp_chk(SEL_STATE, 32'd0, "rst_state");
    exp_chk(SEL_FLUSH, 32'd0, "rst_flush");
    exp_pred(1'b0, 32'h104, "rst");
    step();
    reset = 1'b1;
    init_walk(1'b1, 32'h100);

    // Cold lookup alongside a mispredicted taken resolution of the same PC.
    step();
    drive_fe(1'b1, 32'h100);
    drive_res(32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 32'h104, 8'h00);
    exp_pred(1'b0, 32'h104, "cold");
    exp_chk(SEL_STATE, 32'd1, "run_state");
    exp_chk(SEL_FLUSH, 32'd1, "cold_flush");
    exp_chk(SEL_REDIR, 32'h40, "cold_redir");

    // Now a BTB hit; PHT[0x41] still weak NT; restored GHR = 0x01.
    step();
    res_idle();
    drive_fe(1'b1, 32'h100);
    exp_chk(SEL_GHR, 32'h01, "restore_ghr");
    exp_pred(1'b0, 32'h104, "hit_nt");
    exp_chk(SEL_FLUSH, 32'd0, "idle_flush");

    // Speculative shift of a not-taken hit -> GHR 0x02; correct resolution.
    step();
    drive_fe(1'b0, 32'h100);
    drive_res(32'h100, 1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 8'h00);
    exp_chk(SEL_GHR, 32'h02, "spec_ghr");
    exp_chk(SEL_FLUSH, 32'd0, "correct_flush");
    exp_chk(SEL_REDIR, 32'h40, "correct_redir");

    // Not-taken mispredict restores GHR to 0.
    step();
    drive_res(32'h200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h600, 8'h00);
    exp_chk(SEL_FLUSH, 32'd1, "nt_flush");
    exp_chk(SEL_REDIR, 32'h204, "nt_redir");

    // PHT[0x40] at 11 -> taken to 0x40.
    step();
    res_idle();
    drive_fe(1'b0, 32'h100);
    exp_chk(SEL_GHR, 32'h00, "ghr_zero");
    exp_pred(1'b1, 32'h40, "trained");

    // Flush and hit fetch together: flush wins.
    step();
    drive_fe(1'b1, 32'h100);
    drive_res(32'h304, 1'b1, 32'h80, 1'b0, 1'b0, 32'h308, 8'h5A);
    exp_pred(1'b1, 32'h40, "prio");
    exp_chk(SEL_FLUSH, 32'd1, "prio_flush");
    exp_chk(SEL_REDIR, 32'h80, "prio_redir");

    step();
    res_idle();
    drive_fe(1'b0, 32'hFFFF_FFFC);
    exp_chk(SEL_GHR, 32'hB5, "prio_ghr");
    exp_pred(1'b0, 32'h0, "wrap");

    // Alias: 0x140 shares BTB index 0 with 0x100. Lookup sees pre-edge entry.
    step();
    drive_fe(1'b0, 32'h100);
    drive_res(32'h140, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 8'hB5);
    exp_pred(1'b0, 32'h104, "pre_alias");
    exp_chk(SEL_FLUSH, 32'd0, "alias_flush");

    step();
    res_idle();
    drive_fe(1'b0, 32'h100);
    exp_pred(1'b0, 32'h104, "alias_miss");

    // 0x140 hits, PHT[0xE5]=10 -> taken; speculative shift of 1 -> 0x6B.
    step();
    drive_fe(1'b1, 32'h140);
    exp_pred(1'b1, 32'h80, "alias_hit");

    step();
    drive_fe(1'b0, 32'h140);
    exp_chk(SEL_GHR, 32'h6B, "spec_ghr_t");
    exp_pred(1'b0, 32'h144, "ghr_nt");

    // Unconditional jump: predicted taken regardless of weak-NT PHT.
    step();
    drive_fe(1'b0, 32'h188);
    drive_res(32'h188, 1'b1, 32'h1000, 1'b1, 1'b1, 32'h1000, 8'h6B);
    exp_chk(SEL_FLUSH, 32'd0, "unc_flush");
    exp_chk(SEL_REDIR, 32'h1000, "unc_redir");

    step();
    res_idle();
    drive_fe(1'b0, 32'h188);
    exp_pred(1'b1, 32'h1000, "uncond");

    // Not-taken resolution does not allocate.
    step();
    drive_res(32'h18C, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h190, 8'h6B);
    exp_chk(SEL_FLUSH, 32'd0, "ntok_flush");
    exp_chk(SEL_REDIR, 32'h190, "ntok_redir");

    step();
    res_idle();
    drive_fe(1'b0, 32'h18C);
    exp_pred(1'b0, 32'h190, "no_alloc");
`ifdef BP_STATS_EN
    exp_chk(SEL_ST_BR, 32'd7, "stat_branches");
    exp_chk(SEL_ST_MP, 32'd3, "stat_mispred");
`endif

    // Mid-run reset clears BTB valid bits and restarts INIT.
    step();
    reset = 1'b0;
    drive_fe(1'b1, 32'h188);
    drive_res(32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 32'h104, 8'h00);
    exp_chk(SEL_READY, 32'd0, "mid_rst_ready");
    exp_chk(SEL_FLUSH, 32'd0, "mid_rst_flush");
    exp_pred(1'b0, 32'h18C, "mid_rst");
    step();
    reset = 1'b1;
    init_walk(1'b0, 32'h188);
`ifdef BP_STATS_EN
    exp_chk(SEL_ST_BR, 32'd0, "stat_br_rst");
    exp_chk(SEL_ST_MP, 32'd0, "stat_mp_rst");
`endif

    step();
    res_idle();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
